// File: rtl/plot_framebuffer_if.sv
// Pixel-plot, read-back and clear signals between drawing engines and the framebuffer.
interface plot_framebuffer_if;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [2:0]  plot_colour;
    logic        plot;
    logic        plot_ready;
    logic        rd_req;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_ready;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic        clear;
    logic [2:0]  clear_colour;
    logic        busy;
    logic [15:0] drop_count;

    modport master (
        output plot_x, plot_y, plot_colour, plot, rd_req, rd_x, rd_y, clear, clear_colour,
        input  plot_ready, rd_ready, rd_valid, rd_colour, busy, drop_count
    );

    modport slave (
        input  plot_x, plot_y, plot_colour, plot, rd_req, rd_x, rd_y, clear, clear_colour,
        output plot_ready, rd_ready, rd_valid, rd_colour, busy, drop_count
    );
endinterface

// File: rtl/plot_framebuffer.sv
// 160x120x3 framebuffer: plot write FIFO, read-priority single-port RAM, bulk clear engine.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | reads and FIFO drains share the RAM, reads win
//  ST_CLEAR | RAM filled with latched colour, one address per cycle
module plot_framebuffer #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    plot_framebuffer_if.slave bus
);
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int AW     = 15;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    typedef enum logic {ST_RUN, ST_CLEAR} state_t;

    // Row stride of 160 expressed as shift-add (128 + 32).
    function automatic logic [AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        return (AW'(y) << 7) + (AW'(y) << 5) + AW'(x);
    endfunction

    state_t          state;
    logic            busy_q;
    logic [15:0]     drop_q;
    logic [AW-1:0]   clr_addr;
    logic [2:0]      clr_col;

    logic [AW-1:0]   fifo_addr [FIFO_DEPTH];
    logic [2:0]      fifo_col  [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;

    logic [2:0]      mem [PIXELS];
    logic [2:0]      mem_q;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [2:0]      mem_wdata;

    logic            rd_pend;
    logic            rd_valid_q;
    logic [2:0]      rd_colour_q;

    logic            run;
    logic            fifo_full;
    logic            fifo_empty;
    logic            plot_ready;
    logic            clear_acc;
    logic            plot_acc;
    logic            in_range;
    logic            push;
    logic            drop;
    logic            rd_acc;
    logic            pop;

    assign run        = (state == ST_RUN);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign plot_ready = !fifo_full && run;
    assign clear_acc  = bus.clear && run;
    assign plot_acc   = bus.plot && plot_ready;
    assign in_range   = (int'(bus.plot_x) < WIDTH) && (int'(bus.plot_y) < HEIGHT);
    // A clear in the same cycle flushes the FIFO, so the colliding plot is neither stored nor counted.
    assign push       = plot_acc && in_range && !clear_acc;
    assign drop       = plot_acc && !in_range && !clear_acc;
    assign rd_acc     = bus.rd_req && run;
    assign pop        = run && !rd_acc && !fifo_empty && !clear_acc;

    assign bus.plot_ready = plot_ready;
    assign bus.rd_ready   = run;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_colour  = rd_colour_q;
    assign bus.busy       = busy_q;
    assign bus.drop_count = drop_q;

    // RAM port arbitration: clear sweep, then read, then FIFO head write.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = pix_addr(bus.rd_x, bus.rd_y);
        mem_wdata = fifo_col[rd_ptr];
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = clr_col;
        end else if (!rd_acc && pop) begin
            mem_we   = 1'b1;
            mem_addr = fifo_addr[rd_ptr];
        end
    end

    // Single-port synchronous RAM, one-cycle read latency, no reset on contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_q         <= mem[mem_addr];
    end

    // FIFO payload storage; occupancy and pointers live in the control block.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= pix_addr(bus.plot_x, bus.plot_y);
            fifo_col[wr_ptr]  <= bus.plot_colour;
        end
    end

    // Control: FSM, FIFO pointers, read pipeline and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            busy_q      <= 1'b0;
            drop_q      <= '0;
            clr_addr    <= '0;
            clr_col     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rd_pend     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_colour_q <= '0;
        end else begin
            rd_pend    <= rd_acc;
            rd_valid_q <= rd_pend;
            if (rd_pend) rd_colour_q <= mem_q;

            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;

            case (state)
                ST_RUN: begin
                    if (clear_acc) begin
                        state      <= ST_CLEAR;
                        busy_q     <= 1'b1;
                        clr_addr   <= '0;
                        clr_col    <= bus.clear_colour;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        fifo_count <= '0;
                    end else begin
                        if (push) wr_ptr <= wr_ptr + PW'(1);
                        if (pop)  rd_ptr <= rd_ptr + PW'(1);
                        if (push && !pop)      fifo_count <= fifo_count + CW'(1);
                        else if (pop && !push) fifo_count <= fifo_count - CW'(1);
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == AW'(PIXELS - 1)) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer: reset, clear, plot/readback, drops, starvation, reset abort.
module tb_plot_framebuffer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    plot_framebuffer_if bus ();

    plot_framebuffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] cx [4] = '{8'd0, 8'd159, 8'd0, 8'd159};
    logic [6:0] cy [4] = '{7'd0, 7'd0, 7'd119, 7'd119};
    logic [7:0] sx [5] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read; returns colour seen at +2 and whether rd_valid pulsed exactly at +2.
    task automatic do_read(input logic [7:0] x, input logic [6:0] y,
                           output logic [2:0] col, output logic timing_ok);
        logic v1;
        bus.rd_req = 1'b1;
        bus.rd_x   = x;
        bus.rd_y   = y;
        tick();
        bus.rd_req = 1'b0;
        v1 = bus.rd_valid;
        tick();
        col       = bus.rd_colour;
        timing_ok = !v1 && bus.rd_valid;
        tick();
        timing_ok = timing_ok && !bus.rd_valid;
    endtask

    // Present a plot until accepted (bounded); ok=0 if never accepted.
    task automatic do_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                           output logic ok);
        int n = 0;
        bus.plot        = 1'b1;
        bus.plot_x      = x;
        bus.plot_y      = y;
        bus.plot_colour = c;
        while (!bus.plot_ready && n < 100) begin
            tick();
            n++;
        end
        ok = bus.plot_ready;
        tick();
        bus.plot = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.plot_ready !== 1'b1) begin errors++; $display("FAIL reset_plot_ready: got %b expected 1", bus.plot_ready); end
        checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready: got %b expected 1", bus.rd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", bus.drop_count); end
    endtask

    task automatic test_clear();
        int cnt = 0;
        logic [2:0] c;
        logic ok;
        bus.clear        = 1'b1;
        bus.clear_colour = 3'b010;
        tick();
        bus.clear = 1'b0;
        checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL clear_rd_ready: got %b expected 0", bus.rd_ready); end
        while (bus.busy && cnt < 20010) begin
            cnt++;
            tick();
        end
        checks++; if (cnt != 19200) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 19200", cnt); end
        checks++; if (bus.plot_ready !== 1'b1) begin errors++; $display("FAIL clear_done_plot_ready: got %b expected 1", bus.plot_ready); end
        for (int i = 0; i < 4; i++) begin
            do_read(cx[i], cy[i], c, ok);
            checks++; if (c !== 3'b010) begin errors++; $display("FAIL clear_corner%0d_colour: got %b expected 010", i, c); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clear_corner%0d_timing: got %b expected 1", i, ok); end
        end
    endtask

    task automatic test_plot_readback();
        logic [2:0] c;
        logic ok;
        do_plot(8'd5, 7'd7, 3'b101, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL plot1_accept: got %b expected 1", ok); end
        repeat (2) tick();
        do_read(8'd5, 7'd7, c, ok);
        checks++; if (c !== 3'b101) begin errors++; $display("FAIL plot1_read: got %b expected 101", c); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL plot1_timing: got %b expected 1", ok); end
        do_plot(8'd5, 7'd7, 3'b011, ok);
        repeat (2) tick();
        do_read(8'd5, 7'd7, c, ok);
        checks++; if (c !== 3'b011) begin errors++; $display("FAIL plot2_read: got %b expected 011", c); end
    endtask

    task automatic test_drop();
        logic [2:0] c;
        logic ok;
        do_plot(8'd160, 7'd0, 3'b111, ok);
        do_plot(8'd0, 7'd120, 3'b111, ok);
        tick();
        checks++; if (bus.drop_count !== 16'd2) begin errors++; $display("FAIL drop_count: got %0d expected 2", bus.drop_count); end
        checks++; if (bus.plot_ready !== 1'b1) begin errors++; $display("FAIL drop_fifo_empty: got %b expected 1", bus.plot_ready); end
        do_read(8'd0, 7'd0, c, ok);
        checks++; if (c !== 3'b010) begin errors++; $display("FAIL drop_read_0_0: got %b expected 010", c); end
        do_read(8'd159, 7'd119, c, ok);
        checks++; if (c !== 3'b010) begin errors++; $display("FAIL drop_read_159_119: got %b expected 010", c); end
    endtask

    task automatic test_starvation();
        logic [2:0] c;
        logic ok;
        bus.rd_x   = 8'd0;
        bus.rd_y   = 7'd0;
        bus.rd_req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.plot        = 1'b1;
            bus.plot_x      = sx[i];
            bus.plot_y      = 7'd10;
            bus.plot_colour = 3'(i + 1);
            checks++; if (bus.plot_ready !== 1'b1) begin errors++; $display("FAIL starve_accept%0d: got %b expected 1", i, bus.plot_ready); end
            tick();
        end
        bus.plot_x      = sx[4];
        bus.plot_colour = 3'd5;
        checks++; if (bus.plot_ready !== 1'b0) begin errors++; $display("FAIL starve_full: got %b expected 0", bus.plot_ready); end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL starve_pipelined_valid: got %b expected 1", bus.rd_valid); end
        checks++; if (bus.rd_colour !== 3'b010) begin errors++; $display("FAIL starve_pipelined_colour: got %b expected 010", bus.rd_colour); end
        repeat (3) tick();
        checks++; if (bus.plot_ready !== 1'b0) begin errors++; $display("FAIL starve_still_full: got %b expected 0", bus.plot_ready); end
        bus.rd_req = 1'b0;
        tick();
        checks++; if (bus.plot_ready !== 1'b1) begin errors++; $display("FAIL starve_ready_rises: got %b expected 1", bus.plot_ready); end
        tick();
        bus.plot = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 5; i++) begin
            do_read(sx[i], 7'd10, c, ok);
            checks++; if (c !== 3'(i + 1)) begin errors++; $display("FAIL starve_readback%0d: got %0d expected %0d", i, c, i + 1); end
        end
    endtask

    task automatic test_reset_abort();
        logic [2:0] c;
        logic ok;
        bus.clear        = 1'b1;
        bus.clear_colour = 3'b110;
        tick();
        bus.clear = 1'b0;
        repeat (99) tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", bus.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_async: got %b expected 0", bus.busy); end
        checks++; if (bus.plot_ready !== 1'b1) begin errors++; $display("FAIL abort_plot_ready_async: got %b expected 1", bus.plot_ready); end
        checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL abort_drop_count: got %0d expected 0", bus.drop_count); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", bus.busy); end
        checks++; if (bus.plot_ready !== 1'b1) begin errors++; $display("FAIL abort_plot_ready_after: got %b expected 1", bus.plot_ready); end
        do_plot(8'd20, 7'd30, 3'b111, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_plot_accept: got %b expected 1", ok); end
        repeat (2) tick();
        do_read(8'd20, 7'd30, c, ok);
        checks++; if (c !== 3'b111) begin errors++; $display("FAIL abort_readback: got %b expected 111", c); end
    endtask

    task automatic test_clear_plot_collision();
        int cnt = 0;
        logic [2:0] c;
        logic ok;
        bus.plot         = 1'b1;
        bus.plot_x       = 8'd30;
        bus.plot_y       = 7'd30;
        bus.plot_colour  = 3'b101;
        bus.clear        = 1'b1;
        bus.clear_colour = 3'b001;
        checks++; if (bus.plot_ready !== 1'b1) begin errors++; $display("FAIL collide_ready: got %b expected 1", bus.plot_ready); end
        tick();
        bus.plot  = 1'b0;
        bus.clear = 1'b0;
        checks++; if (bus.plot_ready !== 1'b0) begin errors++; $display("FAIL collide_ready_busy: got %b expected 0", bus.plot_ready); end
        while (bus.busy && cnt < 20010) begin
            cnt++;
            tick();
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL collide_busy_done: got %b expected 0", bus.busy); end
        do_read(8'd30, 7'd30, c, ok);
        checks++; if (c !== 3'b001) begin errors++; $display("FAIL collide_read_30_30: got %b expected 001", c); end
        do_read(8'd20, 7'd30, c, ok);
        checks++; if (c !== 3'b001) begin errors++; $display("FAIL collide_read_20_30: got %b expected 001", c); end
        checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL collide_drop_count: got %0d expected 0", bus.drop_count); end
    endtask

    initial begin
        rst              = 1'b1;
        bus.plot         = 1'b0;
        bus.plot_x       = '0;
        bus.plot_y       = '0;
        bus.plot_colour  = '0;
        bus.rd_req       = 1'b0;
        bus.rd_x         = '0;
        bus.rd_y         = '0;
        bus.clear        = 1'b0;
        bus.clear_colour = '0;
        test_reset();
        test_clear();
        test_plot_readback();
        test_drop();
        test_starvation();
        test_reset_abort();
        test_clear_plot_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/plot_framebuffer.md
Name: plot_framebuffer

Overview:
- Receiving end of the pixel-plot interface that the fill-screen and circle drawers drive (x, y, colour, plot strobe).
- Stores accepted pixels in an on-chip 160x120x3-bit framebuffer.
- Exposes a read port so a scan-out engine or testbench can fetch pixel colours.
- Includes a 4-entry write FIFO, read-priority arbitration on the single-port memory, a bulk clear engine, and a counter for out-of-range plots.

Parameters:
- WIDTH, 160, visible columns; valid x is 0..WIDTH-1.
- HEIGHT, 120, visible rows; valid y is 0..HEIGHT-1.
- FIFO_DEPTH, 4, number of plot-write FIFO entries (power of two).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- plot_x  input  8  plot column.
- plot_y  input  7  plot row.
- plot_colour  input  3  plot colour {R,G,B}.
- plot  input  1  plot strobe; a write is accepted when plot && plot_ready.
- plot_ready  output  1  FIFO can accept a plot this cycle.
- rd_req  input  1  read request; accepted when rd_req && rd_ready.
- rd_x  input  8  read column.
- rd_y  input  7  read row.
- rd_ready  output  1  read port can accept a request.
- rd_valid  output  1  one-cycle pulse; rd_colour is valid.
- rd_colour  output  3  read data.
- clear  input  1  start-clear pulse; ignored while busy.
- clear_colour  input  3  fill value, sampled when clear is accepted.
- busy  output  1  clear in progress.
- drop_count  output  16  number of accepted plots with out-of-range coordinates; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - plot_ready=1, rd_ready=1, rd_valid=0, rd_colour=0, busy=0, drop_count=0.
  - FIFO empty; state RUN.
  - Framebuffer contents are undefined after reset; software clears first.
- Addressing:
  - addr = y*160 + x, computed as (y<<7)+(y<<5)+x in 15 bits.
  - The memory is a single-port synchronous RAM with 1-cycle read latency.
- Plot acceptance:
  - If x>=WIDTH or y>=HEIGHT, the plot is not enqueued and drop_count increments (saturating).
  - Otherwise {addr, colour} is pushed into the FIFO.
  - plot_ready = FIFO not full && state==RUN.
  - A plot presented while plot_ready=0 is not accepted; the sender holds it.
- States: RUN and CLEAR.
- RUN, per-cycle memory arbitration:
  - An accepted read has priority and uses the memory port.
  - Otherwise, if the FIFO is non-empty, the head entry is written and popped.
  - The FIFO may push and pop in the same cycle; occupancy is unchanged.
  - A plot accepted in cycle N is written no earlier than N+1.
- Read timing:
  - A read accepted in cycle N produces rd_valid=1 in cycle N+2 with the registered colour; rd_valid is 0 otherwise.
  - Back-to-back reads are fully pipelined, one per cycle.
  - Reads return memory contents only; FIFO entries not yet written are not forwarded.
  - rd_ready = (state==RUN).
- Continuous reading starves writes. This is intended: the FIFO fills and plot_ready drops.
- RUN to CLEAR:
  - Occurs on clear=1 while in RUN.
  - clear_colour is latched and the FIFO is flushed (pending plots discarded).
  - busy=1, plot_ready=0 and rd_ready=0 from the next cycle.
  - Reads already in flight still complete with pre-clear data.
- CLEAR:
  - Writes the latched colour to addresses 0..19199, one per cycle (19200 cycles).
  - After the last write, returns to RUN; busy=0 and plot_ready=1 on the following cycle.
- Simultaneous clear and plot in the same cycle: clear wins and the plot is not accepted (plot_ready was 1, but the flush discards it; drop_count is unaffected).
- Reset asserted mid-operation returns all outputs to reset values immediately. The clear is abandoned and memory contents become undefined.

Test Plan:
1. Assert rst for 2 cycles, then release -> plot_ready=1, rd_ready=1, busy=0, rd_valid=0, drop_count=0.
2. clear with clear_colour=3'b010 -> busy high for exactly 19200 cycles. Reads of (0,0), (159,0), (0,119), (159,119) each return 3'b010 with rd_valid exactly 2 cycles after the request.
3. Plot (5,7,3'b101), wait 2 cycles, read (5,7) -> rd_colour=3'b101 on cycle +2. Plot (5,7,3'b011), then read again -> 3'b011.
4. Plot (160,0,7) and (0,120,7) -> drop_count=2, FIFO empty, and reads of (0,0) and (159,119) are unchanged.
5. Hold rd_req=1 continuously and present 5 plots -> plot_ready falls after the 4th is accepted. Drop rd_req -> 4 writes drain in 4 cycles, plot_ready rises, the 5th is accepted, and readback of all 5 is correct.
6. Start a clear, pulse rst at cycle 100 -> busy=0 and plot_ready=1 right after reset. A new plot is accepted and reads back correctly.
